branch_resolve: RTL and testbench

- Execute-stage branch resolution unit, directly downstream of the branch comparator (brcomp).
- Drives the comparator's signedness select and consumes its less/equal flags.
- Decides the taken/not-taken outcome for conditional branches and checks it against the fetch-stage prediction.
- Issues a registered redirect/flush to fetch and trains an internal 2-bit bimodal branch history table (BHT), which fetch reads combinationally.

---
 rtl/branch_resolve_if.sv | 64 ++++++
 rtl/branch_resolve.sv | 114 +++++++++++
 tb/tb_branch_resolve.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Bundle between the EX-stage branch resolution unit and its neighbours:
// fetch (lookup/redirect), the EX pipeline latch and the branch comparator.
interface branch_resolve_if #(
   parameter int CNT_W = 32
);

   logic [31:0]      fetch_pc_i;
   logic             pred_taken_o;

   logic             ex_valid_i;
   logic [31:0]      ex_pc_i;
   logic [31:0]      ex_imm_i;
   logic [2:0]       ex_funct3_i;
   logic             ex_pred_taken_i;

   logic             br_unsign_o;
   logic             br_less_i;
   logic             br_equal_i;

   logic             redirect_o;
   logic [31:0]      redirect_pc_o;
   logic             illegal_o;
   logic [CNT_W-1:0] branch_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;

   // The resolution unit itself
   modport slave (
      input  fetch_pc_i,
      output pred_taken_o,
      input  ex_valid_i,
      input  ex_pc_i,
      input  ex_imm_i,
      input  ex_funct3_i,
      input  ex_pred_taken_i,
      output br_unsign_o,
      input  br_less_i,
      input  br_equal_i,
      output redirect_o,
      output redirect_pc_o,
      output illegal_o,
      output branch_cnt_o,
      output mispred_cnt_o
   );

   // The surrounding pipeline that drives it
   modport master (
      output fetch_pc_i,
      input  pred_taken_o,
      output ex_valid_i,
      output ex_pc_i,
      output ex_imm_i,
      output ex_funct3_i,
      output ex_pred_taken_i,
      input  br_unsign_o,
      output br_less_i,
      output br_equal_i,
      input  redirect_o,
      input  redirect_pc_o,
      input  illegal_o,
      input  branch_cnt_o,
      input  mispred_cnt_o
   );

endinterface

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: decides taken/not-taken from the comparator flags,
// issues a registered redirect on mispredict and trains a 2-bit bimodal BHT.
module branch_resolve #(
   parameter int BHT_IDX_W = 6,
   parameter int CNT_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   branch_resolve_if.slave  bus
);

   localparam int BHT_N = 1 << BHT_IDX_W;

   logic [1:0]           r_bht [BHT_N];
   logic                 r_redirect;
   logic [31:0]          r_redirectPc;
   logic                 r_illegal;
   logic [CNT_W-1:0]     r_branchCnt;
   logic [CNT_W-1:0]     r_mispredCnt;

   logic                 w_taken;
   logic                 w_legal;
   logic                 w_ev;
   logic                 w_mispredict;
   logic                 w_resolve;
   logic [31:0]          w_target;
   logic [31:0]          w_fallThrough;
   logic [BHT_IDX_W-1:0] w_exIdx;
   logic [BHT_IDX_W-1:0] w_fetchIdx;
   logic [1:0]           w_exCtr;
   logic                 w_unused;

   assign bus.br_unsign_o = bus.ex_funct3_i[2] & bus.ex_funct3_i[1];

   always_comb begin
      w_taken = 1'b0;
      w_legal = 1'b1;
      case (bus.ex_funct3_i)
         3'b000:         w_taken = bus.br_equal_i;
         3'b001:         w_taken = ~bus.br_equal_i;
         3'b100, 3'b110: w_taken = bus.br_less_i;
         3'b101, 3'b111: w_taken = ~bus.br_less_i;
         default:        w_legal = 1'b0;
      endcase
   end

   // While a redirect is visible the EX slot holds a wrong-path instruction
   assign w_ev          = bus.ex_valid_i & ~r_redirect;
   assign w_resolve     = w_ev & w_legal;
   assign w_mispredict  = w_taken ^ bus.ex_pred_taken_i;
   assign w_target      = bus.ex_pc_i + bus.ex_imm_i;
   assign w_fallThrough = bus.ex_pc_i + 32'd4;

   assign w_exIdx    = bus.ex_pc_i[BHT_IDX_W+1:2];
   assign w_fetchIdx = bus.fetch_pc_i[BHT_IDX_W+1:2];
   assign w_exCtr    = r_bht[w_exIdx];

   assign bus.pred_taken_o = r_bht[w_fetchIdx][1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_N; i++) begin
            r_bht[i] <= 2'b01;
         end
      end else if (w_resolve) begin
         if (w_taken && (w_exCtr != 2'b11)) begin
            r_bht[w_exIdx] <= w_exCtr + 2'd1;
         end else if (!w_taken && (w_exCtr != 2'b00)) begin
            r_bht[w_exIdx] <= w_exCtr - 2'd1;
         end
      end
   end

   // Redirect and illegal are single-cycle pulses; the redirect PC holds between resolves
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_redirect   <= 1'b0;
         r_redirectPc <= 32'd0;
         r_illegal    <= 1'b0;
      end else begin
         r_redirect <= 1'b0;
         r_illegal  <= 1'b0;
         if (w_resolve) begin
            r_redirect   <= w_mispredict;
            r_redirectPc <= w_taken ? w_target : w_fallThrough;
         end else if (w_ev) begin
            r_illegal <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_branchCnt  <= '0;
         r_mispredCnt <= '0;
      end else if (w_resolve) begin
         if (r_branchCnt != '1) begin
            r_branchCnt <= r_branchCnt + 1'b1;
         end
         if (w_mispredict && (r_mispredCnt != '1)) begin
            r_mispredCnt <= r_mispredCnt + 1'b1;
         end
      end
   end

   assign bus.redirect_o    = r_redirect;
   assign bus.redirect_pc_o = r_redirectPc;
   assign bus.illegal_o     = r_illegal;
   assign bus.branch_cnt_o  = r_branchCnt;
   assign bus.mispred_cnt_o = r_mispredCnt;

   assign w_unused = ^{bus.fetch_pc_i[31:BHT_IDX_W+2], bus.fetch_pc_i[1:0]};

endmodule

// File: tb/tb_branch_resolve.sv
// Directed and randomized checks of branch_resolve against an operand-level
// reference model (the bench plays the role of the branch comparator).
module tb_branch_resolve;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   branch_resolve_if #(.CNT_W(32)) brIf ();

   branch_resolve #(.BHT_IDX_W(6), .CNT_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (brIf)
   );

   int          nCompared = 0;
   int          nMismatch = 0;

   // Reference state: one 0..3 confidence value per BHT slot plus expected outputs
   int          bhtM [64];
   logic        expRedirect;
   logic        expIllegal;
   logic [31:0] expPc;
   logic [31:0] expBr;
   logic [31:0] expMis;
   logic [31:0] curFetch;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      assert (obs === exp) else begin
         nMismatch++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> 2) & 32'h3F);
   endfunction

   function automatic logic predOf(input logic [31:0] pc);
      return (bhtM[idxOf(pc)] >= 2);
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 64; i++) bhtM[i] = 1;
      expRedirect = 1'b0;
      expIllegal  = 1'b0;
      expPc       = 32'd0;
      expBr       = 32'd0;
      expMis      = 32'd0;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, " redirect"}, 32'(brIf.redirect_o), 32'(expRedirect));
      check({tag, " illegal"},  32'(brIf.illegal_o),  32'(expIllegal));
      check({tag, " rpc"},      brIf.redirect_pc_o,   expPc);
      check({tag, " brcnt"},    brIf.branch_cnt_o,    expBr);
      check({tag, " miscnt"},   brIf.mispred_cnt_o,   expMis);
      check({tag, " pred"},     32'(brIf.pred_taken_o), 32'(predOf(curFetch)));
   endtask

   // Drive one EX slot from comparator operands a/b, then clock it and compare
   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                                input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic pred, input logic [31:0] fpc, input string tag);
      logic uns;
      logic taken;
      logic legal;
      logic mis;
      int   k;
      uns   = f3[2] & f3[1];
      legal = 1'b1;
      case (f3)
         3'd0:    taken = (a == b);
         3'd1:    taken = (a != b);
         3'd4:    taken = ($signed(a) < $signed(b));
         3'd5:    taken = ($signed(a) >= $signed(b));
         3'd6:    taken = (a < b);
         3'd7:    taken = (a >= b);
         default: begin taken = 1'b0; legal = 1'b0; end
      endcase
      brIf.ex_valid_i      = v;
      brIf.ex_pc_i         = pc;
      brIf.ex_imm_i        = imm;
      brIf.ex_funct3_i     = f3;
      brIf.ex_pred_taken_i = pred;
      brIf.br_equal_i      = (a == b);
      brIf.br_less_i       = uns ? (a < b) : ($signed(a) < $signed(b));
      brIf.fetch_pc_i      = fpc;
      curFetch             = fpc;
      #1;
      check({tag, " unsign"},  32'(brIf.br_unsign_o),  32'(uns));
      check({tag, " prepred"}, 32'(brIf.pred_taken_o), 32'(predOf(fpc)));
      @(posedge clk);
      if (v && !expRedirect && legal) begin
         mis         = taken ^ pred;
         expRedirect = mis;
         expIllegal  = 1'b0;
         expPc       = taken ? (pc + imm) : (pc + 32'd4);
         k           = idxOf(pc);
         if (taken) bhtM[k] = (bhtM[k] == 3) ? 3 : bhtM[k] + 1;
         else       bhtM[k] = (bhtM[k] == 0) ? 0 : bhtM[k] - 1;
         if (expBr != 32'hFFFF_FFFF) expBr = expBr + 32'd1;
         if (mis && expMis != 32'hFFFF_FFFF) expMis = expMis + 32'd1;
      end else if (v && !expRedirect) begin
         expRedirect = 1'b0;
         expIllegal  = 1'b1;
      end else begin
         expRedirect = 1'b0;
         expIllegal  = 1'b0;
      end
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic idle(input string tag);
      applyStimulus(1'b0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 1'b0, curFetch, tag);
   endtask

   initial begin
      logic [31:0] pc;
      logic [31:0] imm;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] fpc;
      logic [31:0] r;
      logic [31:0] savedBr;
      logic [31:0] savedMis;

      rst                  = 1'b1;
      brIf.ex_valid_i      = 1'b0;
      brIf.ex_pc_i         = 32'd0;
      brIf.ex_imm_i        = 32'd0;
      brIf.ex_funct3_i     = 3'd0;
      brIf.ex_pred_taken_i = 1'b0;
      brIf.br_equal_i      = 1'b0;
      brIf.br_less_i       = 1'b0;
      brIf.fetch_pc_i      = 32'h0000_0100;
      curFetch             = 32'h0000_0100;
      modelReset();
      #2;
      checkOutput("reset");
      brIf.fetch_pc_i = 32'h0000_01FC;
      curFetch        = 32'h0000_01FC;
      #1;
      check("reset pred other", 32'(brIf.pred_taken_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // BEQ taken, predicted not-taken
      applyStimulus(1'b1, 32'h100, 32'h20, 3'b000, 32'd5, 32'd5, 1'b0, 32'h100, "beq");
      check("beq rpc const", brIf.redirect_pc_o, 32'h120);
      check("beq pred const", 32'(brIf.pred_taken_o), 32'd1);

      // Wrong-path mispredicting branch in the redirect cycle
      applyStimulus(1'b1, 32'h104, 32'h40, 3'b001, 32'd1, 32'd2, 1'b0, 32'h104, "squash");
      check("squash brcnt const", brIf.branch_cnt_o, 32'd1);
      check("squash redirect const", 32'(brIf.redirect_o), 32'd0);

      // BGEU where signed compare would disagree
      applyStimulus(1'b1, 32'h180, 32'h10, 3'b111, 32'hFFFF_0000, 32'd3, 1'b1, 32'h180, "bgeu");
      check("bgeu rpc const", brIf.redirect_pc_o, 32'h190);

      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'h200, 32'h8, 3'b000, 32'd7, 32'd7, 1'b1, 32'h200, "sat");
      end
      applyStimulus(1'b1, 32'h200, 32'h8, 3'b000, 32'd7, 32'd8, 1'b0, 32'h200, "unsat1");
      check("unsat1 pred const", 32'(brIf.pred_taken_o), 32'd1);
      applyStimulus(1'b1, 32'h200, 32'h8, 3'b000, 32'd7, 32'd8, 1'b0, 32'h200, "unsat2");
      check("unsat2 pred const", 32'(brIf.pred_taken_o), 32'd0);

      applyStimulus(1'b1, 32'hFFFF_FFFC, 32'h8, 3'b000, 32'd1, 32'd1, 1'b0, 32'h0, "wrap");
      check("wrap rpc const", brIf.redirect_pc_o, 32'h0000_0004);
      idle("postwrap");

      savedBr  = brIf.branch_cnt_o;
      savedMis = brIf.mispred_cnt_o;
      applyStimulus(1'b1, 32'h300, 32'h10, 3'b010, 32'd1, 32'd1, 1'b1, 32'h300, "illegal");
      check("illegal pulse const", 32'(brIf.illegal_o), 32'd1);
      check("illegal brcnt hold", brIf.branch_cnt_o, savedBr);
      idle("postillegal");
      check("illegal clear const", 32'(brIf.illegal_o), 32'd0);
      check("illegal miscnt hold", brIf.mispred_cnt_o, savedMis);

      for (int i = 0; i < 300; i++) begin
         pc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         fpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         r   = $urandom;
         imm = {{19{r[12]}}, r[12:1], 1'b0};
         a   = $urandom;
         b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
         applyStimulus(1'(($urandom_range(0, 3) != 0)), pc, imm, 3'($urandom_range(0, 7)),
                       a, b, 1'($urandom_range(0, 1)), fpc, "rand");
      end

      // Asynchronous reset landing while a redirect pulse is visible
      idle("prerst");
      idle("prerst2");
      applyStimulus(1'b1, 32'h140, 32'h20, 3'b000, 32'd9, 32'd9, 1'b0, 32'h140, "prerst beq");
      check("prerst redirect const", 32'(brIf.redirect_o), 32'd1);
      #2;
      rst = 1'b1;
      modelReset();
      #1;
      checkOutput("midrst");
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 32'h140, 32'h20, 3'b001, 32'd9, 32'd9, 1'b1, 32'h140, "postrst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
